// File: rtl/nic8_pkg.sv
// rtl/nic8_pkg.sv - shared types and constants for the nic8 fetch path
package nic8_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        IMM   = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam int    IMM_BIT             = 7;
    localparam byte_t HALT_OPCODE_DEFAULT = 8'hFF;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 8-bit program counter with async reset, jump load and wrapping increment
module pc_reg
    import nic8_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_inc,
    output logic [7:0] o_pc
);

    byte_t r_pc;

    // Load beats increment; the 8-bit add wraps FF -> 00 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + 8'd1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program ROM fetch sequencer: pc, ir, immediate read and halt detection
// Optional macro STALL_EN adds a stall input that freezes pc, ir and state.
module fetch_unit
    import nic8_pkg::*;
#(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] romAddr,
    output logic       romOeBar,
    input  logic [7:0] ibus,
    input  logic       jumpEn,
    input  logic [7:0] jumpTarget,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       immValid,
    output logic       halted
`ifdef STALL_EN
    ,
    input  logic       stall
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    byte_t        r_ir;
    byte_t        w_ir_next;
    byte_t        w_pc;
    logic         w_pc_load;
    logic         w_pc_inc;
    logic         w_hold;

`ifdef STALL_EN
    assign w_hold = stall;
`else
    assign w_hold = 1'b0;
`endif

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_pc_load),
        .i_load_val(jumpTarget),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    // Halt detection outranks a jump; a jump outranks the IMM transition.
    always_comb begin
        w_state_next = r_state;
        w_ir_next    = r_ir;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        if (!w_hold) begin
            case (r_state)
                FETCH: begin
                    w_ir_next = ibus;
                    if (ibus == HALT_OPCODE) begin
                        w_state_next = HALT;
                    end else if (jumpEn) begin
                        w_pc_load    = 1'b1;
                        w_state_next = FETCH;
                    end else begin
                        w_pc_inc     = 1'b1;
                        w_state_next = ibus[IMM_BIT] ? IMM : FETCH;
                    end
                end
                IMM: begin
                    w_pc_load    = jumpEn;
                    w_pc_inc     = !jumpEn;
                    w_state_next = FETCH;
                end
                HALT: begin
                    w_state_next = HALT;
                end
                default: begin
                    w_state_next = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_ir    <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_ir    <= w_ir_next;
        end
    end

    // Decoded straight from the state register so reset releases the bus at once.
    assign romOeBar = (r_state != IMM);
    assign immValid = (r_state == IMM);
    assign halted   = (r_state == HALT);
    assign romAddr  = w_pc;
    assign pc       = w_pc;
    assign ir       = r_ir;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Bus initiator that drives the program ROM: generates the 8-bit address, latches the opcode from the ROM instruction bus, and sequences immediate-operand reads onto the shared data bus via the ROM's active-low output enable.
- Sits between the program ROM and the decode/execute logic.
- Owns the program counter, instruction register, jump loading and halt detection.

Parameters:
- RESET_PC, 8'h00, program counter value after reset.
- HALT_OPCODE, 8'hFF, opcode that parks the unit in HALT.

Ports:
- clk  input  1  system clock, rising edge active
- reset  input  1  asynchronous, active-high reset
- romAddr  output  8  ROM address, always equal to pc
- romOeBar  output  1  active-low ROM data-bus output enable
- ibus  input  8  ROM instruction bus, combinational read of mem[romAddr]
- jumpEn  input  1  load pc from jumpTarget this cycle
- jumpTarget  input  8  jump destination
- pc  output  8  current program counter
- ir  output  8  latched opcode
- immValid  output  1  high during the cycle the immediate byte is on dbus
- halted  output  1  high in HALT state

Behaviour:
- Reset (asynchronous, active-high, legal mid-operation): pc=RESET_PC, ir=8'h00, state=FETCH, romOeBar=1, immValid=0, halted=0. Any in-progress immediate read is abandoned; romOeBar deasserts immediately, not at the next edge.
- States: FETCH, IMM, HALT. Encoded as a 2-bit enum.
- romAddr = pc combinationally. romOeBar = 0 only in IMM, otherwise 1. immValid = (state==IMM). halted = (state==HALT).
- FETCH, on the clock edge:
  - ir <= ibus.
  - If ibus==HALT_OPCODE: state -> HALT, pc unchanged.
  - Else if ibus[IMM_BIT]==1: state -> IMM, pc <= pc+1.
  - Else: state stays FETCH, pc <= pc+1.
- IMM:
  - ROM drives mem[pc] onto dbus for exactly one cycle.
  - On the edge: pc <= pc+1, state -> FETCH.
- HALT: pc, ir and state are frozen; jumpEn is ignored; only reset exits.
- jumpEn, sampled at the edge in FETCH or IMM:
  - pc <= jumpTarget, state -> FETCH. Overrides the increment and the IMM transition.
  - In FETCH, ir still latches ibus.
  - Any path to HALT in the same cycle wins over jumpEn.
- Arithmetic: pc increments modulo 256. 8'hFF+1 -> 8'h00, with no flag and no stall.
- Latency: opcode visible on ir one cycle after romAddr presents it. Instruction cost:
  - 1 cycle, no immediate.
  - 2 cycles, with immediate.
- ibus is never registered except into ir; dbus is never driven by this block.

Optional Feature:
- STALL_EN: adds input port stall (1 bit).
  - While stall=1: pc, ir and state hold.
  - romOeBar, immValid and halted keep their state-derived values; an IMM cycle is held with dbus still driven.
  - stall has priority over jumpEn; reset overrides stall.
- Without STALL_EN: the port is absent and the unit advances every cycle.

Decomposition:
- Shared package nic8_pkg holds:
  - typedef fetch_state_t {FETCH, IMM, HALT}
  - localparam IMM_BIT = 7
  - localparam HALT_OPCODE_DEFAULT = 8'hFF
  - typedef byte_t (logic [7:0])
- Natural sub-module pc_reg: 8-bit register with async reset to RESET_PC, load (jump) and increment enables, and modulo-256 wrap.
- The FSM and ir stay in fetch_unit.

Test Plan:
- Plain sequence: ROM holds 0x01,0x02,0x03 at 0..2, release reset → ir=0x01,0x02,0x03 on cycles 1..3; pc=1,2,3; romOeBar stays 1.
- Immediate read: mem[0]=0x85, mem[1]=0x3C, mem[2]=0x04 → cycle 1 state IMM, romOeBar=0, immValid=1, dbus=0x3C; cycle 2 romOeBar=1, pc=2; cycle 3 ir=0x04.
- Jump during IMM: mem[0]=0x80, jumpEn=1 with jumpTarget=0x40 in IMM cycle → next pc=0x40, state FETCH, no increment; ir next = mem[0x40].
- Wrap and halt: reset with RESET_PC=0xFE, mem[0xFE]=0x01, mem[0xFF]=0x02, mem[0x00]=0xFF → pc sequence FE,FF,00; then halted=1 with pc held at 0x00; jumpEn=1 ignored for 5 cycles.
- Async reset mid-IMM: assert reset between edges while romOeBar=0 → romOeBar=1 and pc=RESET_PC before the next edge; after release, fetch restarts from RESET_PC.
- STALL_EN build: stall=1 for 3 cycles during IMM → dbus held, pc and state unchanged; jumpEn during stall ignored; on release, normal IMM→FETCH.
